// File: rtl/ysyx_24100005_fetch_ctrl.sv
// ysyx_24100005_fetch_ctrl: multi-cycle fetch/execute sequencer owning pc, inst, halt status and perf counters
module ysyx_24100005_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halt,
    output logic [1:0]  halt_code,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret
);
    localparam logic [1:0]  S_REQ    = 2'd0;
    localparam logic [1:0]  S_WAIT   = 2'd1;
    localparam logic [1:0]  S_EXEC   = 2'd2;
    localparam logic [1:0]  S_HALT   = 2'd3;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    logic [1:0]  r_state;
    logic [15:0] r_tmo;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_cycle;
    logic [31:0] r_instret;
    logic [1:0]  r_halt_code;
    logic [1:0]  w_next;
    logic        w_ebreak;
    logic        w_done;
    logic        w_tmo_hit;

    assign w_ebreak  = r_inst == EBREAK;
    assign w_done    = (r_state == S_REQ && imem_req_ready) || (r_state == S_WAIT && imem_rsp_valid);
    // A handshake completing on the last allowed cycle beats the timeout
    assign w_tmo_hit = (r_state == S_REQ || r_state == S_WAIT) && !w_done && r_tmo == TMO_LAST;

    always_comb begin
        w_next = w_tmo_hit              ? S_HALT :
                 r_state == S_REQ       ? (imem_req_ready ? S_WAIT : S_REQ) :
                 r_state == S_WAIT      ? (imem_rsp_valid ? S_EXEC : S_WAIT) :
                 r_state == S_EXEC      ? (w_ebreak ? S_HALT : S_REQ) :
                                          S_HALT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_tmo       <= '0;
            r_pc        <= RESET_PC;
            r_inst      <= '0;
            r_cycle     <= '0;
            r_instret   <= '0;
            r_halt_code <= 2'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC)
                r_tmo <= '0;
            else if (r_state != S_HALT)
                r_tmo <= r_tmo + 16'd1;
            if (r_state == S_WAIT && imem_rsp_valid)
                r_inst <= imem_rsp_data;
            if (r_state == S_EXEC && !w_ebreak)
                r_pc <= next_pc;
            if (r_state == S_EXEC)
                r_instret <= r_instret + 32'd1;
            if (r_state != S_HALT)
                r_cycle <= r_cycle + 32'd1;
            if (r_state == S_EXEC && w_ebreak)
                r_halt_code <= 2'd1;
            else if (w_tmo_hit)
                r_halt_code <= 2'd2;
        end
    end

    assign imem_req_valid = r_state == S_REQ;
    assign imem_addr      = r_pc;
    assign pc             = r_pc;
    assign inst           = r_inst;
    assign rf_wen         = r_state == S_EXEC && !w_ebreak && r_inst[6:0] != 7'b1110011;
    assign pc_wen         = r_state == S_EXEC && !w_ebreak;
    assign halt           = r_state == S_HALT;
    assign halt_code      = r_halt_code;
    assign cycle_cnt      = r_cycle;
    assign instret        = r_instret;
endmodule

// File: tb/tb_ysyx_24100005_fetch_ctrl.sv
// tb_ysyx_24100005_fetch_ctrl: directed scenario bench for the fetch controller (TIMEOUT=8)
module tb_ysyx_24100005_fetch_ctrl;
    localparam logic [31:0] RPC = 32'h8000_0000;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] next_pc = '0;
    logic        imem_req_valid, rf_wen, pc_wen, halt;
    logic [31:0] imem_addr, pc, inst, cycle_cnt, instret;
    logic [1:0]  halt_code;
    int checks = 0;
    int errors = 0;

    ysyx_24100005_fetch_ctrl #(.RESET_PC(RPC), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .next_pc(next_pc),
        .pc(pc), .inst(inst), .rf_wen(rf_wen), .pc_wen(pc_wen), .halt(halt),
        .halt_code(halt_code), .cycle_cnt(cycle_cnt), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0; next_pc = '0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        #2 rst = 1;
        #1;
        checks++; if (pc !== RPC) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc, RPC); end
        checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h exp 0", inst); end
        checks++; if (halt !== 1'b0 || halt_code !== 2'd0) begin errors++; $display("FAIL reset_halt: got %b/%0d exp 0/0", halt, halt_code); end
        checks++; if (cycle_cnt !== 32'h0 || instret !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", cycle_cnt, instret); end
        checks++; if (imem_req_valid !== 1'b1 || rf_wen !== 1'b0 || pc_wen !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b%b exp 100", imem_req_valid, rf_wen, pc_wen); end
        checks++; if (imem_addr !== RPC) begin errors++; $display("FAIL reset_addr: got %h exp %h", imem_addr, RPC); end
        tick();
        rst = 0;
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_pc;
        logic [31:0] d;
        do_reset();
        exp_pc = RPC;
        for (int i = 0; i < 9; i++) begin
            d = 32'h0000_0093 | (32'(i / 3 + 1) << 20);
            if (i % 3 == 0) begin
                imem_req_ready = 1; imem_rsp_valid = 0;
                checks++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc) begin errors++; $display("FAIL zw_req%0d: got %b %h exp 1 %h", i, imem_req_valid, imem_addr, exp_pc); end
            end else if (i % 3 == 1) begin
                imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = d;
                checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL zw_wait%0d: req_valid got %b exp 0", i, imem_req_valid); end
            end else begin
                imem_rsp_valid = 0; next_pc = exp_pc + 4;
                checks++; if (inst !== d || rf_wen !== 1'b1) begin errors++; $display("FAIL zw_exec%0d: got %h %b exp %h 1", i, inst, rf_wen, d); end
            end
            checks++; if (pc_wen !== (i % 3 == 2)) begin errors++; $display("FAIL zw_pcwen%0d: got %b exp %b", i, pc_wen, i % 3 == 2); end
            tick();
            if (i % 3 == 2) exp_pc = exp_pc + 4;
        end
        checks++; if (pc !== 32'h8000_000C) begin errors++; $display("FAIL zw_pc: got %h exp 8000000c", pc); end
        checks++; if (instret !== 32'd3 || cycle_cnt !== 32'd9) begin errors++; $display("FAIL zw_cnt: got %0d/%0d exp 3/9", instret, cycle_cnt); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            imem_req_ready = (i == 5); imem_rsp_valid = (i == 6); imem_rsp_data = 32'h0020_0113;
            next_pc = RPC + 4;
            if (i < 5) begin
                checks++; if (imem_req_valid !== 1'b1 || imem_addr !== RPC) begin errors++; $display("FAIL bp_hold%0d: got %b %h exp 1 %h", i, imem_req_valid, imem_addr, RPC); end
            end
            checks++; if (pc_wen !== (i == 7)) begin errors++; $display("FAIL bp_exec%0d: pc_wen got %b exp %b", i, pc_wen, i == 7); end
            tick();
        end
        imem_req_ready = 1;
        tick();
        imem_req_ready = 0;
        for (int i = 0; i < 4; i++) begin
            imem_rsp_data = 32'hBAD0_0000 + 32'(i);
            tick();
            checks++; if (inst !== 32'h0020_0113) begin errors++; $display("FAIL bp_rspdly%0d: inst got %h exp 00200113", i, inst); end
        end
        imem_rsp_valid = 1; imem_rsp_data = 32'h0030_0193;
        tick();
        imem_rsp_valid = 0;
        checks++; if (inst !== 32'h0030_0193 || pc_wen !== 1'b1) begin errors++; $display("FAIL bp_rsp: got %h %b exp 00300193 1", inst, pc_wen); end
    endtask

    task automatic test_ebreak();
        do_reset();
        imem_req_ready = 1; tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0010_0073; tick();
        imem_rsp_valid = 0; next_pc = 32'h0000_1234;
        checks++; if (rf_wen !== 1'b0 || pc_wen !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL eb_exec: got %b%b%b exp 000", rf_wen, pc_wen, halt); end
        tick();
        checks++; if (halt !== 1'b1 || halt_code !== 2'd1) begin errors++; $display("FAIL eb_halt: got %b/%0d exp 1/1", halt, halt_code); end
        checks++; if (instret !== 32'd1 || pc !== RPC || cycle_cnt !== 32'd3) begin errors++; $display("FAIL eb_state: got %0d %h %0d exp 1 %h 3", instret, pc, cycle_cnt, RPC); end
        imem_req_ready = 1; imem_rsp_valid = 1; imem_rsp_data = 32'h1111_1111;
        for (int i = 0; i < 3; i++) tick();
        imem_req_ready = 0; imem_rsp_valid = 0;
        checks++; if (inst !== 32'h0010_0073 || cycle_cnt !== 32'd3 || instret !== 32'd1) begin errors++; $display("FAIL eb_frozen: got %h %0d %0d exp 00100073 3 1", inst, cycle_cnt, instret); end
        checks++; if (halt !== 1'b1 || imem_req_valid !== 1'b0 || rf_wen !== 1'b0 || pc_wen !== 1'b0) begin errors++; $display("FAIL eb_strobes: got %b%b%b%b exp 1000", halt, imem_req_valid, rf_wen, pc_wen); end
    endtask

    task automatic test_system_op();
        do_reset();
        imem_req_ready = 1; tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0073; tick();
        imem_rsp_valid = 0; next_pc = 32'h8000_0100;
        checks++; if (rf_wen !== 1'b0 || pc_wen !== 1'b1) begin errors++; $display("FAIL sys_exec: got %b%b exp 01", rf_wen, pc_wen); end
        tick();
        checks++; if (halt !== 1'b0 || pc !== 32'h8000_0100 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL sys_after: got %b %h %b exp 0 80000100 1", halt, pc, imem_req_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            imem_req_ready = (i == 0);
            checks++; if (halt !== 1'b0) begin errors++; $display("FAIL to_early%0d: halt got %b exp 0", i, halt); end
            tick();
        end
        imem_req_ready = 0;
        checks++; if (halt !== 1'b1 || halt_code !== 2'd2) begin errors++; $display("FAIL to_halt: got %b/%0d exp 1/2", halt, halt_code); end
        tick(); tick();
        checks++; if (cycle_cnt !== 32'd8 || instret !== 32'd0) begin errors++; $display("FAIL to_cnt: got %0d/%0d exp 8/0", cycle_cnt, instret); end
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        checks++; if (halt_code !== 2'd2 || cycle_cnt !== 32'd8) begin errors++; $display("FAIL to_req: got %0d/%0d exp 2/8", halt_code, cycle_cnt); end
        do_reset();
        for (int i = 0; i < 8; i++) begin
            imem_req_ready = (i == 0); imem_rsp_valid = (i == 7); imem_rsp_data = 32'h0050_0293;
            tick();
        end
        imem_rsp_valid = 0; next_pc = RPC + 4;
        checks++; if (halt !== 1'b0 || pc_wen !== 1'b1 || inst !== 32'h0050_0293) begin errors++; $display("FAIL to_last_rsp: got %b %b %h exp 0 1 00500293", halt, pc_wen, inst); end
        tick();
        checks++; if (halt !== 1'b0 || imem_req_valid !== 1'b1 || pc !== RPC + 4) begin errors++; $display("FAIL to_resume: got %b %b %h exp 0 1 %h", halt, imem_req_valid, pc, RPC + 4); end
    endtask

    task automatic test_async_reset();
        do_reset();
        imem_req_ready = 1; tick();
        imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0060_0313; tick();
        imem_rsp_valid = 0; next_pc = RPC + 4; tick();
        imem_req_ready = 1; tick();
        imem_req_ready = 0;
        checks++; if (imem_req_valid !== 1'b0 || pc !== RPC + 4 || instret !== 32'd1) begin errors++; $display("FAIL ar_pre: got %b %h %0d exp 0 %h 1", imem_req_valid, pc, instret, RPC + 4); end
        #2 rst = 1;
        #1;
        checks++; if (imem_req_valid !== 1'b1 || pc !== RPC || inst !== 32'h0) begin errors++; $display("FAIL ar_now: got %b %h %h exp 1 %h 0", imem_req_valid, pc, inst, RPC); end
        checks++; if (instret !== 32'd0 || cycle_cnt !== 32'd0 || halt !== 1'b0) begin errors++; $display("FAIL ar_cnt: got %0d %0d %b exp 0 0 0", instret, cycle_cnt, halt); end
        @(posedge clk); #1;
        rst = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        imem_rsp_valid = 0;
        checks++; if (inst !== 32'h0 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL ar_stale: got %h %b exp 0 1", inst, imem_req_valid); end
    endtask

    task automatic test_stray();
        do_reset();
        imem_rsp_valid = 1; imem_rsp_data = 32'hAAAA_AAAA; tick();
        checks++; if (inst !== 32'h0 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL st_req: got %h %b exp 0 1", inst, imem_req_valid); end
        imem_req_ready = 1; imem_rsp_data = 32'hBBBB_BBBB; tick();
        imem_req_ready = 0; imem_rsp_valid = 0;
        checks++; if (inst !== 32'h0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL st_accept: got %h %b exp 0 0", inst, imem_req_valid); end
        imem_rsp_valid = 1; imem_rsp_data = 32'h0070_0393; tick();
        imem_rsp_data = 32'hCCCC_CCCC; next_pc = RPC + 8;
        checks++; if (pc_wen !== 1'b1 || inst !== 32'h0070_0393) begin errors++; $display("FAIL st_exec: got %b %h exp 1 00700393", pc_wen, inst); end
        tick();
        imem_rsp_valid = 0;
        checks++; if (inst !== 32'h0070_0393 || imem_req_valid !== 1'b1 || pc !== RPC + 8) begin errors++; $display("FAIL st_after: got %h %b %h exp 00700393 1 %h", inst, imem_req_valid, pc, RPC + 8); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_back_pressure();
        test_ebreak();
        test_system_op();
        test_timeout();
        test_async_reset();
        test_stray();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_24100005_fetch_ctrl.md
# ysyx_24100005_fetch_ctrl

Multi-cycle sequencing controller for the ysyx_24100005 core. It owns the PC and a latched instruction register. It fetches each instruction from an external instruction memory over a valid/ready request and valid response handshake, then releases exactly one execute cycle to the datapath. It gates register-file writes and PC updates, detects `ebreak` and fetch timeouts as halt conditions, and keeps cycle and retired-instruction counters for the simulation environment.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: PC value loaded on reset.
- `TIMEOUT`, default 255: maximum cycles spent in REQ plus WAIT for one fetch; range 1..65535.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_addr` out 32: fetch address, equal to `pc`.
- `imem_rsp_valid` in 1: response data valid.
- `imem_rsp_data` in 32: fetched instruction word.
- `next_pc` in 32: datapath-computed next PC, sampled in EXEC.
- `pc` out 32: current PC register.
- `inst` out 32: latched instruction, stable from EXEC until the next response is captured.
- `rf_wen` out 1: register-file write enable.
- `pc_wen` out 1: PC-update strobe to the datapath.
- `halt` out 1: sticky halt flag.
- `halt_code` out 2: 0 = running, 1 = ebreak, 2 = fetch timeout.
- `cycle_cnt` out 32: count of non-halted cycles.
- `instret` out 32: count of retired instructions.

## Operation
- States: REQ, WAIT, EXEC, HALT, encoded in 2 bits. Reset enters REQ.
- **REQ**
  - `imem_req_valid`=1 and `imem_addr`=`pc`.
  - `imem_req_ready`=1 moves to WAIT.
  - A response is never taken in the same cycle as its acceptance. `imem_rsp_valid` in REQ is ignored.
- **WAIT**
  - `imem_req_valid`=0.
  - `imem_rsp_valid`=1 loads `inst`<=`imem_rsp_data` and moves to EXEC.
- **EXEC**, exactly one cycle:
  - Ebreak is detected when `inst`==32'h0010_0073.
  - Not ebreak: `rf_wen`=1 unless `inst[6:0]`==7'b1110011. `pc_wen`=1, `pc`<=`next_pc`, `instret`+1, then go to REQ.
  - Ebreak: `rf_wen`=0, `pc_wen`=0, `pc` is held, `instret`+1, `halt_code`<=1, then go to HALT.
- **HALT**
  - Absorbing state, left only by `rst`.
  - All strobes are 0, counters are frozen, and `pc`/`inst` are held.
- **Timeout**
  - A 16-bit `tmo` counter clears on entry to REQ from EXEC and on reset.
  - It increments each cycle spent in REQ or WAIT.
  - If `tmo`==`TIMEOUT`-1 in a cycle that does not complete the current phase toward EXEC, the next state is HALT with `halt_code`<=2.
  - A response or request acceptance in that same final cycle wins; there is no timeout.
- `rf_wen` and `pc_wen` are asserted only in EXEC.
- `cycle_cnt` increments every cycle the state is not HALT. It includes the cycle that transitions into HALT.
- Both counters wrap modulo 2^32.
- Reset mid-operation:
  - All state is cleared immediately.
  - Any response still in flight for a pre-reset request that arrives while in REQ is ignored.
  - Stale data in WAIT is accepted. Memory must be reset together with this block.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `inst`=0, `halt`=0, `halt_code`=0, `cycle_cnt`=0, `instret`=0.
  - Outputs in REQ state: `imem_req_valid`=1, `rf_wen`=0, `pc_wen`=0.
- Control outputs (`imem_req_valid`, `rf_wen`, `pc_wen`, `halt`) are decoded from registered state only. There is no combinational path from any input to any output except `imem_addr`=`pc`, which is also registered.
- Minimum instruction latency is 3 cycles: REQ accepted in cycle 0, response in cycle 1, EXEC in cycle 2.
- Each extra cycle of req_ready or rsp latency adds one cycle.
- `pc` changes on the clock edge ending EXEC. The new `imem_addr` is visible in the following REQ cycle.
- `halt` rises on the edge ending the EXEC or timeout cycle.
- `cycle_cnt` equals the number of edges since reset on which the state was not HALT.

## Test plan
- **Zero-wait sequence.** Reset, then memory returns `addi` words at 0x8000_0000/4/8 with ready=1 and rsp_valid one cycle later, and `next_pc`=`pc`+4.
  - Required: `pc_wen` pulses every 3rd cycle, `pc` reaches 0x8000_000C, `instret`=3 after 9 cycles.
- **Back-pressure.**
  - Hold `imem_req_ready`=0 for 5 cycles, then 1. Required: `imem_req_valid` stays 1 with `imem_addr` constant, and EXEC occurs at cycle 7.
  - Delay the response by 4 cycles. Required: `inst` updates only on the rsp_valid cycle.
- **Ebreak.** Fetch 32'h0010_0073.
  - Required: in EXEC `rf_wen`=0 and `pc_wen`=0; then `halt`=1, `halt_code`=1, `instret` incremented, `pc` unchanged.
  - Later rsp_valid or ready pulses cause no change.
- **Timeout.** With `TIMEOUT`=8, never return rsp_valid after acceptance.
  - Required: `halt_code`=2 exactly 8 cycles after entry to REQ, and `cycle_cnt` frozen at 8.
  - Variant: rsp_valid arriving on the 8th cycle is captured, and EXEC follows with no halt.
- **Async reset mid-WAIT.** Assert `rst` between clock edges while in WAIT.
  - Required: outputs return to reset values before the next edge.
  - A stale rsp_valid in the first REQ cycle after reset is ignored; `inst` stays 0.
- **Stray responses.** Pulse rsp_valid during REQ and EXEC. Required: no effect on `inst` or on the state sequence.
